// File: rtl/seg_mux_decoder.sv
// Receiver for a multiplexed 3-digit 7-segment display bus.
// Deglitches the segment/enable buses, decodes each digit as it settles,
// rebuilds the hundreds/tens/units frame and converts it to an 8-bit binary
// value using a two-step multiply-accumulate.
module seg_mux_decoder #(
    parameter int SETTLE = 8
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic [6:0] segments_in,
    input  logic [2:0] enable_in,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       frame_error
);

    typedef enum logic [1:0] {IDLE, CONV1, CONV2, DONE} state_t;

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE);
    localparam logic [7:0] SETTLE_CAP = 8'(SETTLE - 1);

    logic [6:0] seg_reg, seg_prev;
    logic [2:0] en_reg, en_prev;
    logic [7:0] cnt_reg;
    logic       capture;
    logic [3:0] dec_digit;
    logic       dec_ok;
    logic [3:0] h_reg, t_reg, u_reg;
    logic       seen_h_reg, seen_t_reg, bad_reg;
    logic [9:0] acc_reg, acc_next;
    logic [7:0] value_reg;
    logic       ok_reg;
    state_t     state_reg, state_next;

    // x10 as shift-and-add
    function automatic logic [9:0] times10(input logic [9:0] a);
        return (a << 3) + (a << 1);
    endfunction

    // Register the bus once, keep the previous sample and track how long it has been stable
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            seg_reg  <= '0;
            en_reg   <= '0;
            seg_prev <= '0;
            en_prev  <= '0;
            cnt_reg  <= '0;
        end else begin
            seg_reg  <= segments_in;
            en_reg   <= enable_in;
            seg_prev <= seg_reg;
            en_prev  <= en_reg;
            if ({seg_reg, en_reg} == {seg_prev, en_prev}) begin
                if (cnt_reg != SETTLE_MAX)
                    cnt_reg <= cnt_reg + 8'd1;
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // cnt_reg describes how long seg_prev/en_prev has been stable, so capture from those
    assign capture = (cnt_reg == SETTLE_CAP) && (en_prev != 3'b000);

    // Segment pattern to BCD digit; unknown patterns decode to 0 and flag invalid
    always_comb begin
        dec_digit = 4'd0;
        dec_ok    = 1'b1;
        case (seg_prev)
            7'h3F: dec_digit = 4'd0;
            7'h06: dec_digit = 4'd1;
            7'h5B: dec_digit = 4'd2;
            7'h4F: dec_digit = 4'd3;
            7'h66: dec_digit = 4'd4;
            7'h6D: dec_digit = 4'd5;
            7'h7D: dec_digit = 4'd6;
            7'h07: dec_digit = 4'd7;
            7'h7F: dec_digit = 4'd8;
            7'h6F: dec_digit = 4'd9;
            default: dec_ok = 1'b0;
        endcase
    end

    // Frame assembly: store digits, track which slots were seen and any frame fault
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            h_reg      <= '0;
            t_reg      <= '0;
            u_reg      <= '0;
            seen_h_reg <= 1'b0;
            seen_t_reg <= 1'b0;
            bad_reg    <= 1'b0;
        end else begin
            if (state_reg == DONE) begin
                h_reg   <= '0;
                t_reg   <= '0;
                u_reg   <= '0;
                bad_reg <= 1'b0;
            end
            if (capture) begin
                case (en_prev)
                    3'b100: begin
                        h_reg      <= dec_digit;
                        seen_h_reg <= 1'b1;
                        if (!dec_ok || seen_h_reg || seen_t_reg)
                            bad_reg <= 1'b1;
                    end
                    3'b010: begin
                        t_reg      <= dec_digit;
                        seen_t_reg <= 1'b1;
                        if (!dec_ok || seen_t_reg)
                            bad_reg <= 1'b1;
                    end
                    3'b001: begin
                        u_reg      <= dec_digit;
                        seen_h_reg <= 1'b0;
                        seen_t_reg <= 1'b0;
                        if (!dec_ok)
                            bad_reg <= 1'b1;
                    end
                    default: bad_reg <= 1'b1;
                endcase
            end
        end
    end

    // Second multiply-accumulate step, shared by the datapath and the range check
    always_comb begin
        acc_next = times10(acc_reg) + {6'd0, u_reg};
    end

    // Conversion datapath; the outcome is decided on entry to DONE so the pulse lands in DONE
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            value_reg <= '0;
            ok_reg    <= 1'b0;
        end else begin
            case (state_reg)
                CONV1: acc_reg <= times10({6'd0, h_reg}) + {6'd0, t_reg};
                CONV2: begin
                    acc_reg <= acc_next;
                    if (!bad_reg && (acc_next <= 10'd255)) begin
                        value_reg <= acc_next[7:0];
                        ok_reg    <= 1'b1;
                    end else begin
                        ok_reg    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // FSM next state: a units capture closes the frame and starts conversion
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture && (en_prev == 3'b001)) state_next = CONV1;
            CONV1:   state_next = CONV2;
            CONV2:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: exactly one of the two pulses fires in DONE
    always_comb begin
        value       = value_reg;
        value_valid = (state_reg == DONE) && ok_reg;
        frame_error = (state_reg == DONE) && !ok_reg;
    end

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Bench for seg_mux_decoder: frame table plus hand-written corner sequences,
// with a scoreboard checking kind, value and cycle of every output pulse.
module tb_seg_mux_decoder;

    localparam int SETTLE = 8;
    localparam int HOLD   = 20;

    logic       hwclk;
    logic       rst;
    logic [6:0] segments_in;
    logic [2:0] enable_in;
    logic [7:0] value;
    logic       value_valid;
    logic       frame_error;

    seg_mux_decoder #(.SETTLE(SETTLE)) dut (
        .hwclk       (hwclk),
        .rst         (rst),
        .segments_in (segments_in),
        .enable_in   (enable_in),
        .value       (value),
        .value_valid (value_valid),
        .frame_error (frame_error)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    int cyc = 0;
    always @(posedge hwclk) cyc <= cyc + 1;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic       err;
        logic [7:0] val;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [6:0] sh; logic [2:0] eh;
        logic [6:0] st; logic [2:0] et;
        logic [6:0] su;
        logic       err;
        logic [7:0] val;
    } vec_t;
    vec_t vecs[12];

    logic [7:0] good = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic slot(input logic [6:0] s, input logic [2:0] en, input int n);
        segments_in = s;
        enable_in   = en;
        repeat (n) @(negedge hwclk);
    endtask

    // Units slot closes a frame: queue the expected pulse, then hold the bus
    task automatic units(input logic [6:0] s, input logic err, input logic [7:0] val, input int n);
        exp_t e;
        segments_in = s;
        enable_in   = 3'b001;
        e.err = err;
        e.val = err ? good : val;
        e.cyc = cyc + SETTLE + 4;
        sb.push_back(e);
        if (!err) good = val;
        repeat (n) @(negedge hwclk);
    endtask

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge hwclk) begin
        if (!rst && (value_valid || frame_error)) begin
            if (sb.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b error=%0b value=%0d required no pulse (cycle %0d)",
                         value_valid, frame_error, value, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {30'd0, value_valid, frame_error}, e.err ? 32'd1 : 32'd2);
                check("value", {24'd0, value}, {24'd0, e.val});
                check("latency", cyc, e.cyc);
                $display("[TB] frame done: valid=%0b error=%0b value=%0d cycle=%0d",
                         value_valid, frame_error, value, cyc);
            end
        end
    end

    initial begin
        vecs[0]  = '{7'h7F, 3'b000, 7'h7F, 3'b000, 7'h07, 1'b0, 8'd7};
        vecs[1]  = '{7'h7F, 3'b000, 7'h06, 3'b010, 7'h3F, 1'b0, 8'd10};
        vecs[2]  = '{7'h7F, 3'b000, 7'h00, 3'b010, 7'h06, 1'b1, 8'd0};
        vecs[3]  = '{7'h06, 3'b100, 7'h3F, 3'b010, 7'h3F, 1'b0, 8'd100};
        vecs[4]  = '{7'h5B, 3'b100, 7'h6F, 3'b010, 7'h6F, 1'b1, 8'd0};
        vecs[5]  = '{7'h5B, 3'b110, 7'h7F, 3'b000, 7'h3F, 1'b1, 8'd0};
        vecs[6]  = '{7'h06, 3'b100, 7'h7F, 3'b010, 7'h66, 1'b0, 8'd184};
        vecs[7]  = '{7'h5B, 3'b100, 7'h4F, 3'b010, 7'h6D, 1'b0, 8'd235};
        vecs[8]  = '{7'h7F, 3'b000, 7'h6F, 3'b010, 7'h07, 1'b0, 8'd97};
        vecs[9]  = '{7'h6F, 3'b100, 7'h6F, 3'b010, 7'h6F, 1'b1, 8'd0};
        vecs[10] = '{7'h3F, 3'b100, 7'h3F, 3'b010, 7'h3F, 1'b0, 8'd0};
        vecs[11] = '{7'h5B, 3'b100, 7'h6D, 3'b010, 7'h66, 1'b0, 8'd254};

        rst = 1'b1;
        segments_in = 7'h00;
        enable_in = 3'b000;
        repeat (3) @(negedge hwclk);
        check("reset_value", {24'd0, value}, 32'd0);
        check("reset_valid", {31'd0, value_valid}, 32'd0);
        check("reset_error", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        slot(7'h00, 3'b000, 5);

        // Full-scale frame with long holds: 2,5,5 -> 255
        slot(7'h5B, 3'b100, 300);
        slot(7'h6D, 3'b010, 300);
        units(7'h6D, 1'b0, 8'd255, 300);

        for (int i = 0; i < 12; i++) begin
            slot(vecs[i].sh, vecs[i].eh, HOLD);
            slot(vecs[i].st, vecs[i].et, HOLD);
            units(vecs[i].su, vecs[i].err, vecs[i].val, HOLD);
        end

        // Enable glitch shorter than the settle window must not capture
        units(7'h4F, 1'b0, 8'd3, HOLD);
        slot(7'h4F, 3'b010, SETTLE - 1);
        units(7'h4F, 1'b0, 8'd3, HOLD);

        // Reset while the FSM is in CONV1 aborts the conversion
        slot(7'h7F, 3'b000, HOLD);
        segments_in = 7'h06;
        enable_in   = 3'b001;
        repeat (SETTLE + 2) @(negedge hwclk);
        rst = 1'b1;
        segments_in = 7'h00;
        enable_in   = 3'b000;
        good = 8'd0;
        repeat (2) @(negedge hwclk);
        rst = 1'b0;
        repeat (15) @(negedge hwclk);
        check("value_after_reset", {24'd0, value}, 32'd0);

        // Fresh frame after reset: 1,2,3 -> 123
        slot(7'h06, 3'b100, HOLD);
        slot(7'h5B, 3'b010, HOLD);
        units(7'h4F, 1'b0, 8'd123, HOLD);
        slot(7'h00, 3'b000, HOLD);

        for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge hwclk);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("value_held", {24'd0, value}, {24'd0, good});

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
